// File: rtl/mem_arbiter_if.sv
// Fetch, data-stage and memory-side signals of the shared memory port.
// slave is the arbiter view; master is the requester/memory view.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        halt;
    logic        createdump;
    logic        err;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;

    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
        input  halt, mem_rdata, mem_done,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done,
        output dm_stall, createdump, err,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
        output halt, mem_rdata, mem_done,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done,
        input  dm_stall, createdump, err,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data accesses onto one stalling memory port,
// with a BUSY watchdog and the one-shot HALT dump sequence.
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  arb
);

    typedef enum logic [2:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY,
        DUMP,
        HALTED
    } state_t;

    state_t      state_q;
    logic [7:0]  wd_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] if_rdata_q;
    logic [15:0] dm_rdata_q;
    logic        en_q;
    logic        wr_q;
    logic        if_done_q;
    logic        dm_done_q;
    logic        err_q;
    logic        dump_q;

    logic dm_req;
    logic if_ok;
    logic dm_bad;
    logic if_bad;

    // A port whose done is high this cycle is still holding its old request.
    assign dm_req = (arb.dm_rd | arb.dm_wr) & ~dm_done_q;
    assign if_ok  = arb.if_req & ~if_done_q;
    assign dm_bad = (arb.dm_rd & arb.dm_wr) | arb.dm_addr[0];
    assign if_bad = arb.if_addr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wd_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            err_q      <= 1'b0;
            dump_q     <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            err_q     <= 1'b0;
            dump_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dm_req) begin
                        if (dm_bad) begin
                            err_q      <= 1'b1;
                            dm_done_q  <= 1'b1;
                            dm_rdata_q <= '0;
                        end else begin
                            state_q <= DM_BUSY;
                            en_q    <= 1'b1;
                            wr_q    <= arb.dm_wr;
                            addr_q  <= arb.dm_addr;
                            wdata_q <= arb.dm_wdata;
                            wd_q    <= '0;
                        end
                    end else if (arb.halt) begin
                        state_q <= DUMP;
                        dump_q  <= 1'b1;
                    end else if (if_ok) begin
                        if (if_bad) begin
                            err_q      <= 1'b1;
                            if_done_q  <= 1'b1;
                            if_rdata_q <= '0;
                        end else begin
                            state_q <= IF_BUSY;
                            en_q    <= 1'b1;
                            wr_q    <= 1'b0;
                            addr_q  <= arb.if_addr;
                            wdata_q <= '0;
                            wd_q    <= '0;
                        end
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (arb.mem_done) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        if (state_q == IF_BUSY) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= arb.mem_rdata;
                        end else begin
                            dm_done_q <= 1'b1;
                            if (!wr_q)
                                dm_rdata_q <= arb.mem_rdata;
                        end
                    end else if (wd_q == TIMEOUT) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        err_q   <= 1'b1;
                        if (state_q == IF_BUSY) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= '0;
                        end else begin
                            dm_done_q  <= 1'b1;
                            dm_rdata_q <= '0;
                        end
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                DUMP:    state_q <= HALTED;
                HALTED:  state_q <= HALTED;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.mem_en     = en_q;
    assign arb.mem_wr     = wr_q;
    assign arb.mem_addr   = addr_q;
    assign arb.mem_wdata  = wdata_q;
    assign arb.if_rdata   = if_rdata_q;
    assign arb.dm_rdata   = dm_rdata_q;
    assign arb.if_done    = if_done_q;
    assign arb.dm_done    = dm_done_q;
    assign arb.err        = err_q;
    assign arb.createdump = dump_q;
    assign arb.if_stall   = arb.if_req & ~if_done_q;
    assign arb.dm_stall   = (arb.dm_rd | arb.dm_wr) & ~dm_done_q;

endmodule
